// File: rtl/stopwatch_pkg.sv
// Shared constants for the stopwatch display path: segment codes, scan width and FSM encoding.
package stopwatch_pkg;

  localparam int unsigned SCAN_W     = 2;
  localparam int unsigned BCD_W      = 4;
  localparam int unsigned SEG_W      = 7;
  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  // Four display digits, leftmost (minutes tens) in the MSBs
  typedef struct packed {
    bcd_t d3;
    bcd_t d2;
    bcd_t d1;
    bcd_t d0;
  } digits_t;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;

  localparam logic [0:0] ST_LIVE   = 1'b0;
  localparam logic [0:0] ST_FROZEN = 1'b1;

endpackage

// File: rtl/stopwatch_display_scan_seg7_encode.sv
// BCD to active-low seven-segment decoder; non-BCD values show a dash.
module seg7_encode
  import stopwatch_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (bcd)
      4'd0: seg_c = SEG_0;
      4'd1: seg_c = SEG_1;
      4'd2: seg_c = SEG_2;
      4'd3: seg_c = SEG_3;
      4'd4: seg_c = SEG_4;
      4'd5: seg_c = SEG_5;
      4'd6: seg_c = SEG_6;
      4'd7: seg_c = SEG_7;
      4'd8: seg_c = SEG_8;
      4'd9: seg_c = SEG_9;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/stopwatch_display_scan.sv
// Multiplexes four BCD digits onto a common-anode display with a lap/freeze snapshot.
// Optional: define LEADING_ZERO_BLANK_EN to blank a leading zero on the minutes-tens digit.
module stopwatch_display_scan
  import stopwatch_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [BCD_W-1:0]      digit0,
  input  logic [BCD_W-1:0]      digit1,
  input  logic [BCD_W-1:0]      digit2,
  input  logic [BCD_W-1:0]      digit3,
  input  logic                  lap,
  input  logic                  clear,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      seg,
  output logic                  dp,
  output logic                  frozen
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0]  refresh_cnt;
  logic [SCAN_W-1:0] scan_idx;
  logic [0:0]        state;
  logic [0:0]        state_next;
  digits_t           snapshot;
  bcd_t              cur_digit_c;
  logic [SEG_W-1:0]  enc_seg_c;
  logic [SEG_W-1:0]  cur_seg_c;
  logic              refresh_wrap_c;

  assign refresh_wrap_c = (refresh_cnt == CNT_W'(REFRESH_DIV - 1));

  // Refresh timer and scan position
  always_ff @(posedge clock) begin
    if (reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_wrap_c) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + SCAN_W'(1);
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
    end
  end

  // Lap/clear state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_LIVE;
    end else begin
      state <= state_next;
    end
  end

  // Clear wins over lap; lap toggles between live and frozen
  always_comb begin
    state_next = state;
    case (state)
      ST_LIVE:   if (!clear && lap) state_next = ST_FROZEN;
      ST_FROZEN: if (clear || lap)  state_next = ST_LIVE;
      default:   state_next = ST_LIVE;
    endcase
  end

  // Snapshot tracks the inputs while live, including on the lap edge itself
  always_ff @(posedge clock) begin
    if (reset) begin
      snapshot <= '0;
    end else if (state == ST_LIVE) begin
      snapshot <= '{d3: digit3, d2: digit2, d1: digit1, d0: digit0};
    end
  end

  always_comb begin
    cur_digit_c = snapshot.d0;
    case (scan_idx)
      2'd0: cur_digit_c = snapshot.d0;
      2'd1: cur_digit_c = snapshot.d1;
      2'd2: cur_digit_c = snapshot.d2;
      2'd3: cur_digit_c = snapshot.d3;
      default: cur_digit_c = snapshot.d0;
    endcase
  end

  seg7_encode u_seg7_encode (
    .bcd   (cur_digit_c),
    .seg_c (enc_seg_c)
  );

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    cur_seg_c = ((scan_idx == 2'd3) && (snapshot.d3 == 4'd0)) ? SEG_BLANK : enc_seg_c;
`else
    cur_seg_c = enc_seg_c;
`endif
  end

  // Registered display pins; frozen follows the state register
  always_ff @(posedge clock) begin
    if (reset) begin
      an     <= '1;
      seg    <= SEG_BLANK;
      dp     <= 1'b1;
      frozen <= 1'b0;
    end else begin
      an     <= ~(NUM_DIGITS'(1) << scan_idx);
      seg    <= cur_seg_c;
      dp     <= (scan_idx != 2'd2);
      frozen <= (state_next == ST_FROZEN);
    end
  end

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Randomized and directed checks of stopwatch_display_scan against a cycle-count reference model.
module tb_stopwatch_display_scan;

  localparam int unsigned DIV = 4;

  logic       clock;
  logic       reset;
  logic [3:0] digit0, digit1, digit2, digit3;
  logic       lap, clear;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frozen;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [6:0] seg_tbl [16];
  logic [3:0] m_snap [4];
  logic       m_frozen;
  int         m_n;
  logic [3:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  stopwatch_display_scan #(.REFRESH_DIV(DIV)) dut (
    .clock  (clock),
    .reset  (reset),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3),
    .lap    (lap),
    .clear  (clear),
    .an     (an),
    .seg    (seg),
    .dp     (dp),
    .frozen (frozen)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then compare
  task automatic step(input logic [3:0] d3, input logic [3:0] d2, input logic [3:0] d1,
                      input logic [3:0] d0, input logic l, input logic c, input logic r);
    int idx;
    digit3 = d3; digit2 = d2; digit1 = d1; digit0 = d0;
    lap = l; clear = c; reset = r;
    @(posedge clock);
    if (r) begin
      m_n = 0;
      m_frozen = 1'b0;
      for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
      exp_an = 4'b1111;
      exp_seg = 7'b1111111;
      exp_dp = 1'b1;
    end else begin
      idx = (m_n / DIV) % 4;
      exp_an = 4'b1111;
      exp_an[idx] = 1'b0;
      exp_seg = seg_tbl[m_snap[idx]];
`ifdef LEADING_ZERO_BLANK_EN
      if (idx == 3 && m_snap[3] == 4'd0) exp_seg = 7'b1111111;
`endif
      exp_dp = (idx != 2);
      if (!m_frozen) begin
        m_snap[0] = d0; m_snap[1] = d1; m_snap[2] = d2; m_snap[3] = d3;
      end
      if (c) m_frozen = 1'b0;
      else if (l) m_frozen = !m_frozen;
      m_n++;
    end
    #1;
    check_eq("an", 32'(an), 32'(exp_an));
    check_eq("seg", 32'(seg), 32'(exp_seg));
    check_eq("dp", 32'(dp), 32'(exp_dp));
    check_eq("frozen", 32'(frozen), 32'(m_frozen));
    @(negedge clock);
  endtask

  initial begin
    int guard;
    seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001; seg_tbl[2] = 7'b0100100;
    seg_tbl[3] = 7'b0110000; seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
    seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000; seg_tbl[8] = 7'b0000000;
    seg_tbl[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) seg_tbl[i] = 7'b0111111;
    m_n = 0; m_frozen = 1'b0;
    for (int i = 0; i < 4; i++) m_snap[i] = 4'd0;
    digit0 = 4'd0; digit1 = 4'd0; digit2 = 4'd0; digit3 = 4'd0;
    lap = 1'b0; clear = 1'b0; reset = 1'b1;
    @(negedge clock);

    step(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    step(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1);
    check_eq("reset_an", 32'(an), 32'h0000000F);
    check_eq("reset_seg", 32'(seg), 32'h0000007F);

    // Hold 1,2,3,4 for a full scan and more
    for (int i = 0; i < 20; i++) step(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0);

    // Freeze on 5,9,0,7 then change inputs
    step(4'd5, 4'd9, 4'd0, 4'd7, 1'b1, 1'b0, 1'b0);
    check_eq("lap_freezes", 32'(frozen), 32'd1);
    for (int i = 0; i < 18; i++) step(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    step(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_eq("lap_unfreezes", 32'(frozen), 32'd0);
    for (int i = 0; i < 18; i++) step(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);

    // lap+clear together while live stays live; clear alone leaves frozen
    step(4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 1'b1, 1'b0);
    check_eq("lap_clear_live", 32'(frozen), 32'd0);
    step(4'd3, 4'd3, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0);
    step(4'd6, 4'd6, 4'd6, 4'd6, 1'b0, 1'b1, 1'b0);
    check_eq("clear_from_frozen", 32'(frozen), 32'd0);

    // Non-BCD on digit1 shows a dash
    for (int i = 0; i < 18; i++) step(4'd1, 4'd2, 4'hC, 4'd8, 1'b0, 1'b0, 1'b0);

    // Reset mid-scan while frozen at scan index 2
    step(4'd2, 4'd3, 4'd4, 4'd5, 1'b1, 1'b0, 1'b0);
    guard = 0;
    while (((m_n / DIV) % 4) != 2 && guard < 64) begin
      step(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check_eq("reach_idx2_bound", 32'(guard < 64), 32'd1);
    step(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
    check_eq("frozen_before_reset", 32'(frozen), 32'd1);
    step(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 1'b1);
    check_eq("midscan_rst_an", 32'(an), 32'h0000000F);
    check_eq("midscan_rst_dp", 32'(dp), 32'd1);
    check_eq("midscan_rst_frozen", 32'(frozen), 32'd0);
    step(4'd7, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0, 1'b0);
    check_eq("restart_an", 32'(an), 32'h0000000E);

    // Leading zero on digit3
    for (int i = 0; i < 20; i++) step(4'd0, 4'd4, 4'd2, 4'd9, 1'b0, 1'b0, 1'b0);

    // Randomized traffic with occasional lap, clear and reset
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_scan.md
Name: stopwatch_display_scan

Overview:
- Downstream stage of the stopwatch counter chain.
- Takes the four BCD digits (min tens, min ones, sec tens, sec ones) and time-multiplexes them onto a 4-digit common-anode seven-segment display.
- Provides a lap/freeze function: the display can hold a snapshot while the counters keep running.
- Outputs connect directly to the board display pins.

Parameters:
- REFRESH_DIV, 50000: clock cycles each digit stays lit before the scan advances. Must be ≥ 2. The counter width is ceil(log2(REFRESH_DIV)).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- digit0  in  4  BCD seconds ones (rightmost digit)
- digit1  in  4  BCD seconds tens
- digit2  in  4  BCD minutes ones
- digit3  in  4  BCD minutes tens (leftmost digit)
- lap  in  1  single-cycle pulse; toggles between live and frozen display
- clear  in  1  single-cycle pulse; forces live display
- an  out  4  anode enables, active-low; an[i] drives digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- frozen  out  1  1 while the display shows a held snapshot

Behaviour:
- Interface rule: reset is reset, synchronous, active-high; clock is clock.
- Reset values:
  - an = 4'b1111, seg = 7'b1111111, dp = 1, frozen = 0.
  - Scan index = 0, refresh counter = 0, snapshot = all zero, state = LIVE.
- Refresh counter:
  - Counts 0 .. REFRESH_DIV-1 and wraps to 0.
  - On the cycle it wraps, scan index advances 0→1→2→3→0.
  - Each digit is therefore active for exactly REFRESH_DIV cycles.
- State machine, 2 states:
  - LIVE: the snapshot register loads digit0..3 every cycle.
  - LIVE + lap → FROZEN. The snapshot keeps the values it loaded on the lap cycle, i.e. the inputs present on that edge.
  - FROZEN: the snapshot holds.
  - FROZEN + lap → LIVE.
  - clear in either state → LIVE. clear has priority over a simultaneous lap.
  - frozen = 1 exactly when state = FROZEN; it is registered with the state.
- Output stage:
  - an, seg and dp are registered.
  - They are computed from the current scan index and the snapshot, so an changes one cycle after the index changes.
  - Input-to-seg latency in LIVE is 2 cycles.
- an: exactly one bit low, at position scan index. The only exception is reset, when all bits are high.
- seg encoding, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value 10–15 shows a dash: 0111111.
- dp: 0 only while scan index = 2, giving MM.SS; 1 otherwise.
- Reset mid-scan: on the next edge, all state returns to reset values, including leaving FROZEN.
- lap and clear are sampled every cycle and do not depend on the refresh counter.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN
- Defined: when scan index = 3 and snapshot digit3 = 0, seg = 7'b1111111. Digits 0–2 are never blanked.
- Not defined: digit3 always shows its decoded value, including 0.

Decomposition:
- Package stopwatch_pkg holds:
  - Segment constants: SEG_BLANK, SEG_DASH, and the ten digit codes.
  - State encoding: ST_LIVE, ST_FROZEN.
  - Scan index width constant = 2.
- One combinational sub-module, seg7_encode: 4-bit BCD in, 7-bit active-low seg out, dash for values > 9. Shared with any other display user.
- The refresh counter, FSM, snapshot register and output register stay in the top module.

Test Plan (all with REFRESH_DIV=4):
- Reset, then hold inputs 1,2,3,4 (digit3..0) → an cycles 1110,1101,1011,0111, each for 4 cycles. Seg codes match 4,3,2,1 respectively; dp=0 only while an=1011.
- Pulse lap with inputs 5,9,0,7, then change inputs to 0,0,0,0 → frozen=1 and the display keeps showing 5,9,0,7. A second lap → frozen=0 and the display shows 0,0,0,0 within 2 cycles.
- lap and clear asserted together while LIVE → state stays LIVE, frozen=0. In FROZEN, clear alone → LIVE.
- digit1 = 4'hC → seg = 0111111 while an=1101.
- reset asserted mid-scan (index 2, FROZEN) → the next cycle shows an=1111, seg=1111111, dp=1, frozen=0. Scanning restarts at an=1110.
- digit3 = 0: with LEADING_ZERO_BLANK_EN, seg = 1111111 while an=0111. Without it, seg = 1000000.
